dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter placed in front of the single-ported data memory. It shares the memory between the CPU load/store port (port A) and the debug/loader port (port B), granting at most one access per cycle. It drives the memory's address, write-data and read/write strobes, and returns registered read data to the winning requester. The memory side is unchanged: writes commit on the clock edge, and reads are combinational from the word address `memAddr>>2`.

## Interface
- `AW`, 32: address width in bits (byte address).
- `DW`, 32: data width in bits.
- `clk` input 1: the single clock; everything samples on posedge.
- `reset` input 1: synchronous, active-high reset.
- `a_req`, `b_req` input 1: access request, held until granted.
- `a_we`, `b_we` input 1: 1 = write, 0 = read.
- `a_addr`, `b_addr` input AW: byte address.
- `a_wdata`, `b_wdata` input DW: write data.
- `a_gnt`, `b_gnt` output 1: combinational grant; the access is performed in this cycle.
- `a_rvalid`, `b_rvalid` output 1: registered one-cycle pulse; read data is valid.
- `a_rdata`, `b_rdata` output DW: registered read data; held until the next read completes on that port.
- `a_err`, `b_err` output 1: registered one-cycle pulse; a misaligned access was dropped.
- `memAddr` output AW: address to memory.
- `memWriteData` output DW: write data to memory.
- `MemWrite`, `MemRead` output 1: memory strobes.
- `memReadData` input DW: combinational read data from memory.

## Operation
- **Arbitration.** Each cycle, select a winner from the requesting ports.
  - With only one port requesting, that port wins.
  - On a tie, the winner is set by the policy in Configuration.
  - Raise `x_gnt` for the winner only; the loser sees `gnt`=0 and must hold its request.
- **Memory drive.**
  - The winner's addr and wdata are muxed onto `memAddr` and `memWriteData`.
  - `MemWrite` = `gnt & we & aligned`.
  - `MemRead` = `gnt & ~we & aligned`.
  - With no grant, all memory outputs are 0.
- **Alignment.** An access is aligned when `addr[1:0]`==0.
  - A misaligned access is still granted so the requester can retire it.
  - No memory strobe is raised.
  - `x_err` pulses on the next cycle.
- **Read return.**
  - On the grant edge, `memReadData` is captured into `x_rdata`.
  - `x_rvalid` pulses in the following cycle.
- **Write return.** No `rvalid`; the write is complete at the grant edge.
- **Per-port state.** `last` records which port was last granted. It updates only on cycles with a grant.
- Requester protocol: a port may change addr, we or wdata only after a cycle in which it was granted.

## Timing
- **Reset values.**
  - `a_gnt`, `b_gnt`, `MemWrite`, `MemRead`, `memAddr`, `memWriteData` are 0 while `reset`=1. Grants are forced low.
  - `x_rvalid`, `x_err`, `x_rdata` reset to 0.
  - `last` resets to B, so A wins the first tie.
- **Latency.**
  - Grant is in the same cycle as the request, when it wins.
  - Read data and `rvalid` arrive exactly 1 cycle after the grant.
  - `err` arrives 1 cycle after the grant.
- **Throughput.** Each port can complete one access per cycle when it is alone. Back-to-back reads return back-to-back `rvalid`s.
- **Simultaneous events.**
  - A read on a port completes the same cycle that port's next access is granted: `rvalid` for the old read and `gnt` for the new access are both high.
  - The other port's `rdata` is unaffected.
- **Reset mid-operation.**
  - A request present during a reset cycle is not granted and produces no `rvalid` or `err`.
  - In the reset cycle, the `rvalid` or `err` owed to the previous cycle's grant is also forced to 0.
- **Wrap-around.** `memAddr` passes through unmodified. The memory's word indexing handles truncation.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a tie, grant the port that is not `last`, so the ports alternate under continuous contention.
- Undefined: fixed priority. Port A always wins ties, and `last` is still maintained but unused.
- Misaligned handling and all timing are identical in both builds.

## Test plan
- **Reset then single read.** Preload word 4 = 32'hDEADBEEF. A reads addr 32'h10. Required: `a_gnt` in cycle 0, `MemRead`=1, `memAddr`=32'h10. Cycle 1: `a_rvalid`=1, `a_rdata`=32'hDEADBEEF.
- **Write-then-read, same port.** B writes 32'h12345678 to 32'h20, then reads 32'h20. Required: `MemWrite` in cycle 0, read granted in cycle 1, `b_rdata`=32'h12345678 in cycle 2.
- **Continuous contention, 4 cycles, both ports reading.**
  - RR build: grants A,B,A,B.
  - Fixed build: grants A,A,A,A, with `b_gnt`=0 throughout.
- **Misaligned access.** A writes to 32'h13. Required: `a_gnt`=1, `MemWrite`=0, memory unchanged, `a_err`=1 next cycle, no `a_rvalid`.
- **Reset mid-read.** A's read is granted in cycle 0, and `reset` is asserted in cycle 1. Required: `a_rvalid`=0 and `a_rdata`=0 in cycle 1, and the next tie after reset goes to A.
- **Idle.** No requests for 3 cycles. Required: all memory strobes 0, and `last` unchanged, confirmed by the next tie's winner.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: grant in the request cycle, read data/err one cycle later.
// Loser holds its request; tie policy is fixed A-priority, or round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memWriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] memReadData
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic          last_q, last_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic          a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          tie_to_a;
  logic          a_aligned, b_aligned;

`ifdef DMEM_ARB_RR_EN
  assign tie_to_a = (last_q == PORT_B);
`else
  assign tie_to_a = 1'b1;
`endif

  assign a_aligned = (a_addr[1:0] == 2'b00);
  assign b_aligned = (b_addr[1:0] == 2'b00);

  always_comb begin
    a_gnt = a_req & ~reset & (~b_req | tie_to_a);
    b_gnt = b_req & ~reset & ~a_gnt;
  end

  always_comb begin
    memAddr      = '0;
    memWriteData = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    if (a_gnt) begin
      memAddr      = a_addr;
      memWriteData = a_wdata;
      MemWrite     = a_we & a_aligned;
      MemRead      = ~a_we & a_aligned;
    end else if (b_gnt) begin
      memAddr      = b_addr;
      memWriteData = b_wdata;
      MemWrite     = b_we & b_aligned;
      MemRead      = ~b_we & b_aligned;
    end
  end

  always_comb begin
    last_d     = last_q;
    a_rvalid_d = a_gnt & ~a_we & a_aligned;
    b_rvalid_d = b_gnt & ~b_we & b_aligned;
    a_err_d    = a_gnt & ~a_aligned;
    b_err_d    = b_gnt & ~b_aligned;
    a_rdata_d  = a_rvalid_d ? memReadData : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? memReadData : b_rdata_q;
    if (a_gnt) begin
      last_d = PORT_A;
    end else if (b_gnt) begin
      last_d = PORT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= PORT_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Reset also cancels the completion owed to the grant of the cycle before it.
  always_comb begin
    a_rvalid = a_rvalid_q & ~reset;
    b_rvalid = b_rvalid_q & ~reset;
    a_err    = a_err_q & ~reset;
    b_err    = b_err_q & ~reset;
    a_rdata  = reset ? '0 : a_rdata_q;
    b_rdata  = reset ? '0 : b_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model behind it.
module tb_dmem_arbiter;
  logic        clk;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] memAddr, memWriteData, memReadData;
  logic        MemWrite, MemRead;

  logic [31:0] mem [0:63];
  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .memAddr(memAddr), .memWriteData(memWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memReadData = mem[memAddr[7:2]];
  always @(posedge clk) begin
    if (MemWrite) mem[memAddr[7:2]] <= memWriteData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
  endtask

  logic exp_a [0:3];
  logic exp_b [0:3];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
`ifdef DMEM_ARB_RR_EN
    exp_a[0] = 1; exp_a[1] = 0; exp_a[2] = 1; exp_a[3] = 0;
`else
    exp_a[0] = 1; exp_a[1] = 1; exp_a[2] = 1; exp_a[3] = 1;
`endif
    for (int i = 0; i < 4; i++) exp_b[i] = ~exp_a[i];

    // Reset with a pending request: nothing granted, nothing strobed.
    reset = 1'b1;
    drive_a(1'b1, 1'b0, 32'h10, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_a_gnt", {31'b0, a_gnt}, 32'd0);
    check("rst_memread", {31'b0, MemRead}, 32'd0);
    check("rst_memaddr", memAddr, 32'h0);
    next_cycle;
    @(negedge clk);
    check("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_a_err", {31'b0, a_err}, 32'd0);

    // Single read on A.
    next_cycle;
    reset = 1'b0;
    @(negedge clk);
    check("rd_a_gnt", {31'b0, a_gnt}, 32'd1);
    check("rd_memread", {31'b0, MemRead}, 32'd1);
    check("rd_memaddr", memAddr, 32'h10);
    next_cycle;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rd_a_rvalid", {31'b0, a_rvalid}, 32'd1);
    check("rd_a_rdata", a_rdata, 32'hDEADBEEF);

    // B write then read of the same word.
    next_cycle;
    check("rd_a_rvalid_off", {31'b0, a_rvalid}, 32'd0);
    check("rd_a_rdata_hold", a_rdata, 32'hDEADBEEF);
    drive_b(1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    check("wr_b_gnt", {31'b0, b_gnt}, 32'd1);
    check("wr_memwrite", {31'b0, MemWrite}, 32'd1);
    check("wr_memread", {31'b0, MemRead}, 32'd0);
    check("wr_memwdata", memWriteData, 32'h12345678);
    next_cycle;
    drive_b(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("wr_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    check("rd_b_gnt", {31'b0, b_gnt}, 32'd1);
    check("rd_b_memread", {31'b0, MemRead}, 32'd1);
    next_cycle;
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rd_b_rvalid", {31'b0, b_rvalid}, 32'd1);
    check("rd_b_rdata", b_rdata, 32'h12345678);
    check("rd_b_a_rdata_kept", a_rdata, 32'hDEADBEEF);

    // Continuous contention, both reading; last grant so far was B.
    next_cycle;
    drive_a(1'b1, 1'b0, 32'h10, 32'h0);
    drive_b(1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("cont_a_gnt%0d", i), {31'b0, a_gnt}, {31'b0, exp_a[i]});
      check($sformatf("cont_b_gnt%0d", i), {31'b0, b_gnt}, {31'b0, exp_b[i]});
      if (i > 0) begin
        check($sformatf("cont_a_rv%0d", i), {31'b0, a_rvalid}, {31'b0, exp_a[i-1]});
        check($sformatf("cont_b_rv%0d", i), {31'b0, b_rvalid}, {31'b0, exp_b[i-1]});
      end
      next_cycle;
    end
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("cont_a_rv4", {31'b0, a_rvalid}, {31'b0, exp_a[3]});
    check("cont_b_rv4", {31'b0, b_rvalid}, {31'b0, exp_b[3]});
    check("cont_a_rdata", a_rdata, 32'hDEADBEEF);

    // Misaligned write on A: granted, dropped, err next cycle.
    next_cycle;
    drive_a(1'b1, 1'b1, 32'h13, 32'hCAFEF00D);
    @(negedge clk);
    check("mis_a_gnt", {31'b0, a_gnt}, 32'd1);
    check("mis_memwrite", {31'b0, MemWrite}, 32'd0);
    check("mis_memread", {31'b0, MemRead}, 32'd0);
    next_cycle;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("mis_a_err", {31'b0, a_err}, 32'd1);
    check("mis_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    check("mis_mem_word4", mem[4], 32'hDEADBEEF);

    // Idle for 3 cycles; last (A) must persist.
    for (int i = 0; i < 3; i++) begin
      next_cycle;
      @(negedge clk);
      check($sformatf("idle_strobes%0d", i), {30'b0, MemWrite, MemRead}, 32'd0);
      check($sformatf("idle_memaddr%0d", i), memAddr, 32'h0);
      if (i == 0) check("idle_a_err_off", {31'b0, a_err}, 32'd0);
    end
    next_cycle;
    drive_a(1'b1, 1'b0, 32'h10, 32'h0);
    drive_b(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
`ifdef DMEM_ARB_RR_EN
    check("idle_tie_b_gnt", {31'b0, b_gnt}, 32'd1);
`else
    check("idle_tie_a_gnt", {31'b0, a_gnt}, 32'd1);
`endif

    // Address passes through unmodified; memory wraps by word index.
    next_cycle;
    drive_a(1'b1, 1'b0, 32'hFFFFFF10, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("wrap_memaddr", memAddr, 32'hFFFFFF10);

    // Reset arrives the cycle after A's read grant.
    next_cycle;
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    drive_b(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("rstmid_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    check("rstmid_a_rdata", a_rdata, 32'h0);
    check("rstmid_b_gnt", {31'b0, b_gnt}, 32'd0);
    next_cycle;
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rstmid_tie_a_gnt", {31'b0, a_gnt}, 32'd1);
    check("rstmid_tie_b_gnt", {31'b0, b_gnt}, 32'd0);
    check("rstmid_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    next_cycle;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("post_a_rvalid", {31'b0, a_rvalid}, 32'd1);
    check("post_a_rdata", a_rdata, 32'hDEADBEEF);
    check("post_b_rdata", b_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
